// File: rtl/cs161_trace_buffer_if.sv
// Trace buffer bus: processor observation inputs, capture control and the
// valid/ready read port toward the debug host.
//   master : drives processor/capture/host-ready signals, observes the read port
//   slave  : the trace buffer itself
// Record layout on rd_data: {pc[74:43], opcode[42:37], wr_addr[36:32], wr_data[31:0]}
interface cs161_trace_buffer_if #(
  parameter int ADDR_W = 4,
  parameter int OVF_W  = 16
);
  logic              capture_en;
  logic              trig_pc_en;
  logic [31:0]       trig_pc;
  logic [31:0]       prog_count;
  logic [5:0]        instr_opcode;
  logic [4:0]        write_reg_addr;
  logic [31:0]       write_reg_data;
  logic              rd_ready;
  logic              rd_valid;
  logic [74:0]       rd_data;
  logic [ADDR_W:0]   count;
  logic [OVF_W-1:0]  overflow_cnt;
  logic [1:0]        trace_state;

  modport master (
    output capture_en, trig_pc_en, trig_pc, prog_count, instr_opcode,
           write_reg_addr, write_reg_data, rd_ready,
    input  rd_valid, rd_data, count, overflow_cnt, trace_state
  );

  modport slave (
    input  capture_en, trig_pc_en, trig_pc, prog_count, instr_opcode,
           write_reg_addr, write_reg_data, rd_ready,
    output rd_valid, rd_data, count, overflow_cnt, trace_state
  );
endinterface

// File: rtl/cs161_trace_buffer.sv
// Commit-trace capture FIFO. Each clock it packs the processor's PC, opcode,
// write-back address and data into a 75-bit record and, when the capture FSM
// allows, pushes it into a DEPTH-entry register FIFO drained over a
// valid/ready read port. Records arriving while the FIFO is full (and not
// being popped) are dropped and counted in a saturating overflow counter.
// Ports:
//   clk   - sole clock, rising edge
//   rst   - asynchronous active-high reset (pointers, count, counter, FSM)
//   flush - synchronous clear of FIFO, counter and FSM; beats everything else
//   tb_if - trace bus (slave modport): capture control, processor
//           observation inputs, read port, count, overflow_cnt, trace_state
module cs161_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int OVF_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  cs161_trace_buffer_if.slave   tb_if
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [OVF_W-1:0]   ovf_q, ovf_d;
  logic [74:0]        mem_q [DEPTH];

  logic [74:0] record;
  logic        push_req;
  logic        pop;
  logic        push_ok;
  logic        drop;
  logic        mem_we;

  assign record = {tb_if.prog_count, tb_if.instr_opcode,
                   tb_if.write_reg_addr, tb_if.write_reg_data};

  // Capture FSM: next state and whether this edge's record is a push request.
  always_comb begin
    state_d  = ST_IDLE;
    push_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tb_if.capture_en)
          state_d = tb_if.trig_pc_en ? ST_ARMED : ST_CAPTURE;
        else
          state_d = ST_IDLE;
      end
      ST_ARMED: begin
        if (!tb_if.capture_en) begin
          state_d = ST_IDLE;
        end else if (tb_if.prog_count == tb_if.trig_pc) begin
          // The trigger cycle's own record is the first one captured.
          state_d  = ST_CAPTURE;
          push_req = 1'b1;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        if (tb_if.capture_en) begin
          state_d  = ST_CAPTURE;
          push_req = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping. A full FIFO still accepts a push when the head is
  // popped on the same edge, so sustained full-rate streaming never drops.
  always_comb begin
    pop      = (count_q != '0) && tb_if.rd_ready;
    push_ok  = push_req && ((count_q != FULL_CNT) || pop);
    drop     = push_req && !push_ok;
    mem_we   = push_ok && !flush;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = drop ? sat_inc(ovf_q) : ovf_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= flush ? ST_IDLE : state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Record storage is not reset; validity is carried by count_q alone.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[wr_ptr_q] <= record;
  end

  assign tb_if.rd_valid     = (count_q != '0);
  assign tb_if.rd_data      = mem_q[rd_ptr_q];
  assign tb_if.count        = count_q;
  assign tb_if.overflow_cnt = ovf_q;
  assign tb_if.trace_state  = state_q;

endmodule

// File: tb/tb_cs161_trace_buffer.sv
module tb_cs161_trace_buffer;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  cs161_trace_buffer_if #(.ADDR_W(4), .OVF_W(16)) bus ();

  cs161_trace_buffer #(.DEPTH(16), .ADDR_W(4), .OVF_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .tb_if (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [74:0] exp_q[$];

  function automatic logic [74:0] mk(input logic [31:0] pc);
    logic [5:0] op;
    logic [4:0] ra;
    op = pc[7:2] ^ 6'h15;
    ra = pc[6:2];
    return {pc, op, ra, ~pc};
  endfunction

  task automatic set_pc(input logic [31:0] pc);
    logic [74:0] r;
    r = mk(pc);
    bus.prog_count     = r[74:43];
    bus.instr_opcode   = r[42:37];
    bus.write_reg_addr = r[36:32];
    bus.write_reg_data = r[31:0];
  endtask

  task automatic chk(input string nm, input logic [74:0] act, input logic [74:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive point: 2 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.capture_en = 1'b0;
    bus.trig_pc_en = 1'b0;
    bus.trig_pc = 32'h0;
    bus.rd_ready = 1'b0;
    set_pc(32'h0);

    // Monitor: a pop happens at the next edge when valid & ready are seen here.
    fork
      forever begin
        @(negedge clk);
        if (!rst && !flush && bus.rd_valid && bus.rd_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got %0h expected no record", bus.rd_data);
          end else begin
            chk("rd_data", bus.rd_data, exp_q.pop_front());
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_count", 75'(bus.count), 75'(0));
    chk("rst_valid", 75'(bus.rd_valid), 75'(0));
    chk("rst_state", 75'(bus.trace_state), 75'(0));
    chk("rst_ovf", 75'(bus.overflow_cnt), 75'(0));

    // Immediate capture, host stalled: fill and overflow.
    bus.capture_en = 1'b1;
    set_pc(32'h100);
    tick();
    chk("idle_to_capture", 75'(bus.trace_state), 75'(2));
    chk("no_push_in_idle", 75'(bus.count), 75'(0));
    for (int i = 0; i < 20; i++) begin
      set_pc(32'(4 * i));
      if (i < 16) exp_q.push_back(mk(32'(4 * i)));
      tick();
    end
    chk("fill_count", 75'(bus.count), 75'(16));
    chk("fill_ovf", 75'(bus.overflow_cnt), 75'(4));
    chk("fill_head", bus.rd_data, mk(32'h0));

    // Full FIFO streaming: push and pop every edge.
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_pc(32'(80 + 4 * i));
      exp_q.push_back(mk(32'(80 + 4 * i)));
      tick();
    end
    chk("stream_count", 75'(bus.count), 75'(16));
    chk("stream_ovf", 75'(bus.overflow_cnt), 75'(4));

    // Stop capture and drain everything.
    bus.capture_en = 1'b0;
    repeat (16) tick();
    chk("drain_count", 75'(bus.count), 75'(0));
    chk("drain_valid", 75'(bus.rd_valid), 75'(0));
    chk("drain_state", 75'(bus.trace_state), 75'(0));
    chk("drain_queue", 75'(exp_q.size()), 75'(0));
    bus.rd_ready = 1'b0;

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ovf_clear", 75'(bus.overflow_cnt), 75'(0));

    // Armed trigger at PC 0x20.
    bus.trig_pc_en = 1'b1;
    bus.trig_pc = 32'h20;
    bus.capture_en = 1'b1;
    set_pc(32'h1000);
    tick();
    chk("armed_state", 75'(bus.trace_state), 75'(1));
    for (int i = 0; i < 8; i++) begin
      set_pc(32'(4 * i));
      tick();
    end
    chk("armed_wait_state", 75'(bus.trace_state), 75'(1));
    chk("armed_wait_count", 75'(bus.count), 75'(0));
    set_pc(32'h20);
    exp_q.push_back(mk(32'h20));
    tick();
    chk("trig_state", 75'(bus.trace_state), 75'(2));
    chk("trig_count", 75'(bus.count), 75'(1));
    chk("trig_head", bus.rd_data, mk(32'h20));
    bus.trig_pc_en = 1'b0;
    bus.trig_pc = 32'h0;
    for (int i = 1; i < 5; i++) begin
      set_pc(32'(32'h20 + 4 * i));
      exp_q.push_back(mk(32'(32'h20 + 4 * i)));
      tick();
    end
    bus.capture_en = 1'b0;
    set_pc(32'h999);
    tick();
    chk("stop_state", 75'(bus.trace_state), 75'(0));
    chk("stop_count", 75'(bus.count), 75'(5));
    bus.rd_ready = 1'b1;
    repeat (5) tick();
    chk("armed_drain_count", 75'(bus.count), 75'(0));
    chk("armed_drain_valid", 75'(bus.rd_valid), 75'(0));
    bus.rd_ready = 1'b0;

    // Flush with count=9, overflow=3 and a pop requested.
    bus.capture_en = 1'b1;
    set_pc(32'h2000);
    tick();
    for (int i = 0; i < 19; i++) begin
      set_pc(32'(32'h3000 + 4 * i));
      if (i < 16) exp_q.push_back(mk(32'(32'h3000 + 4 * i)));
      tick();
    end
    bus.capture_en = 1'b0;
    bus.rd_ready = 1'b1;
    repeat (7) tick();
    chk("pre_flush_count", 75'(bus.count), 75'(9));
    chk("pre_flush_ovf", 75'(bus.overflow_cnt), 75'(3));
    bus.capture_en = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.capture_en = 1'b0;
    bus.rd_ready = 1'b0;
    exp_q.delete();
    chk("flush_count", 75'(bus.count), 75'(0));
    chk("flush_ovf", 75'(bus.overflow_cnt), 75'(0));
    chk("flush_state", 75'(bus.trace_state), 75'(0));
    chk("flush_valid", 75'(bus.rd_valid), 75'(0));

    // Asynchronous reset between edges with 7 entries held.
    bus.capture_en = 1'b1;
    set_pc(32'h4000);
    tick();
    for (int i = 0; i < 7; i++) begin
      set_pc(32'(32'h5000 + 4 * i));
      exp_q.push_back(mk(32'(32'h5000 + 4 * i)));
      tick();
    end
    bus.capture_en = 1'b0;
    tick();
    chk("pre_rst_count", 75'(bus.count), 75'(7));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 75'(bus.count), 75'(0));
    chk("async_rst_valid", 75'(bus.rd_valid), 75'(0));
    chk("async_rst_state", 75'(bus.trace_state), 75'(0));
    exp_q.delete();
    bus.capture_en = 1'b1;
    tick();
    chk("in_rst_state", 75'(bus.trace_state), 75'(0));
    rst = 1'b0;
    tick();
    chk("resume_state", 75'(bus.trace_state), 75'(2));
    chk("resume_count", 75'(bus.count), 75'(0));
    set_pc(32'h6000);
    exp_q.push_back(mk(32'h6000));
    tick();
    chk("resume_push", 75'(bus.count), 75'(1));
    bus.capture_en = 1'b0;
    bus.rd_ready = 1'b1;
    tick();
    chk("final_count", 75'(bus.count), 75'(0));
    chk("final_queue", 75'(exp_q.size()), 75'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
